aes_core_sequencer: RTL
=======================

Name: aes_core_sequencer

Overview:
- Host-side initiator for the AES core's init/next/ready/result_valid handshake.
- Takes a key-load request and a stream of blocks over valid/ready channels, then issues init and next pulses to the core.
- Holds key, keylen, encdec and block stable toward the core for the whole operation, and buffers each result in a one-entry output register with backpressure.
- Has a watchdog that flags a core that never returns ready.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles spent in a wait state before abort (1..65535)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
key_load_valid  in  1  key load request
key_load_ready  out  1  key load accepted when both high
key_in  in  256  key; 128-bit mode uses bits [127:0]
keylen_in  in  1  0 = 128-bit, 1 = 256-bit
in_valid  in  1  block request
in_ready  out  1  block accepted when both high
in_encdec  in  1  1 = encipher, 0 = decipher
in_block  in  128  input block
out_valid  out  1  result buffer full
out_ready  in  1  downstream takes result
out_block  out  128  result
key_loaded  out  1  expanded key valid in core
err  out  1  sticky timeout flag
err_clear  in  1  clears err
core_init  out  1  to core init
core_next  out  1  to core next
core_encdec  out  1  to core encdec
core_key  out  256  to core key
core_keylen  out  1  to core keylen
core_block  out  128  to core block
core_ready  in  1  from core ready
core_result  in  128  from core result
core_result_valid  in  1  from core result_valid

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE.
  - All data registers are cleared; key_loaded, err, out_valid, core_init and core_next are 0.
  - key_load_ready is 1 and in_ready is 0.
  - A reset mid-operation abandons the operation; the core is reset alongside.
- States: IDLE, ISSUE_INIT, WAIT_INIT, ISSUE_NEXT, WAIT_NEXT.
- core_init is decoded from state==ISSUE_INIT and core_next from state==ISSUE_NEXT.
  - Each is exactly one cycle wide.
  - Both come from registered state only.
- key_load_ready = (state==IDLE).
- in_ready = (state==IDLE) && key_loaded && !key_load_valid && (!out_valid || out_ready).
  - Key load has priority; a block is never accepted in a cycle where a key load is offered.
- IDLE, key handshake:
  - Latch key_in and keylen_in into core_key and core_keylen.
  - Clear key_loaded and go to ISSUE_INIT.
- ISSUE_INIT: go to WAIT_INIT and clear the timeout counter.
- WAIT_INIT:
  - The ISSUE cycle exists because core ready is registered and falls only one cycle after the pulse; WAIT therefore never sees a stale ready.
  - core_ready=1: set key_loaded, go to IDLE.
- IDLE, block handshake:
  - Latch in_block into core_block and in_encdec into core_encdec.
  - Go to ISSUE_NEXT, then WAIT_NEXT.
- WAIT_NEXT, core_ready=1 and core_result_valid=1:
  - Capture core_result into out_block, set out_valid, go to IDLE.
  - The buffer is guaranteed free, because acceptance required it to be empty or draining.
- core_encdec, core_key, core_keylen and core_block change only on an IDLE handshake; they are stable through ISSUE and WAIT.
- out_valid clears on out_valid && out_ready.
  - If a capture and a drain happen in the same cycle, the capture wins and out_valid stays 1.
- Timeout counter, 16 bits:
  - Counts every WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 with core_ready still low, the sequencer sets err and goes to IDLE.
  - WAIT_INIT abort: key_loaded stays 0.
  - WAIT_NEXT abort: the block is dropped and nothing is written to out.
- err clears on err_clear; if a set and a clear happen in the same cycle, set wins.
- Latency: block handshake at edge 0, core_next high in cycle 1, result captured on the edge where core_ready rises, out_valid high the following cycle. Overhead is 2 cycles over the core.
- A new key load is legal any time in IDLE; it invalidates key_loaded until its WAIT_INIT completes.

Test Plan:
1. Reset, then load key 000102..0f with keylen 0, then encipher 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a; core_init and core_next each exactly 1 cycle wide; key_loaded=1 before in_ready rises.
2. Load key 000102..1f with keylen 1, then encipher the same block -> 8ea2b7ca516745bfeafc49904b496089; decipher that ciphertext -> original plaintext; core_encdec is stable throughout WAIT_NEXT.
3. Hold out_ready=0 after the first result with in_valid=1 -> in_ready stays 0 and out_block holds. Then raise out_ready for 1 cycle -> the second block is accepted in that same cycle and there is no data loss.
4. Assert key_load_valid and in_valid together in IDLE -> the key is accepted, in_ready=0 that cycle, and key_loaded drops until init completes.
5. Stub core holding core_ready=0 with TIMEOUT_CYCLES=16 -> err=1 after 16 WAIT cycles, state returns to IDLE, and out_valid stays 0. Then pulse err_clear -> err=0.
6. Assert reset mid-WAIT_NEXT -> all outputs reach their reset values immediately (asynchronously); after release, key_loaded=0 and in_ready=0.

Source files
------------

// File: rtl/aes_core_sequencer.sv
// Host-side sequencer for the AES core init/next/ready/result_valid handshake.
// Accepts key loads and blocks over valid/ready channels and buffers one result.
module aes_core_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         key_load_valid,
   output logic         key_load_ready,
   input  logic [255:0] key_in,
   input  logic         keylen_in,

   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_encdec,
   input  logic [127:0] in_block,

   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,

   output logic         key_loaded,
   output logic         err,
   input  logic         err_clear,

   output logic         core_init,
   output logic         core_next,
   output logic         core_encdec,
   output logic [255:0] core_key,
   output logic         core_keylen,
   output logic [127:0] core_block,
   input  logic         core_ready,
   input  logic [127:0] core_result,
   input  logic         core_result_valid,

   output logic [2:0]   state_dbg
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE_INIT = 3'd1,
      WAIT_INIT  = 3'd2,
      ISSUE_NEXT = 3'd3,
      WAIT_NEXT  = 3'd4
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [15:0] wait_cnt;
   logic        key_hs;
   logic        blk_hs;
   logic        drain;
   logic        wait_expired;

   // All channels transfer on the rising edge where valid and ready are both
   // high; valid must hold with stable data until that edge, ready may change
   // freely. A key load offered in IDLE always wins over a pending block.
   assign key_load_ready = (state == IDLE);
   assign in_ready       = (state == IDLE) && key_loaded && !key_load_valid &&
                           (!out_valid || out_ready);

   assign key_hs       = key_load_valid && key_load_ready;
   assign blk_hs       = in_valid && in_ready;
   assign drain        = out_valid && out_ready;
   assign wait_expired = (wait_cnt == TIMEOUT_LAST);
   assign state_dbg    = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= 16'd0;
         key_loaded  <= 1'b0;
         err         <= 1'b0;
         out_valid   <= 1'b0;
         out_block   <= 128'd0;
         core_init   <= 1'b0;
         core_next   <= 1'b0;
         core_encdec <= 1'b0;
         core_key    <= 256'd0;
         core_keylen <= 1'b0;
         core_block  <= 128'd0;
      end else begin
         // Pulses are set only on entry to the ISSUE states, so each lasts one cycle.
         core_init <= 1'b0;
         core_next <= 1'b0;

         // Clears are written first so a same-cycle set or capture overrides them.
         if (err_clear) begin
            err <= 1'b0;
         end
         if (drain) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (key_hs) begin
                  core_key    <= key_in;
                  core_keylen <= keylen_in;
                  key_loaded  <= 1'b0;
                  core_init   <= 1'b1;
                  state       <= ISSUE_INIT;
               end else if (blk_hs) begin
                  core_block  <= in_block;
                  core_encdec <= in_encdec;
                  core_next   <= 1'b1;
                  state       <= ISSUE_NEXT;
               end
            end

            // The core drops ready one cycle after the pulse, so the WAIT
            // states never observe a stale ready from the previous operation.
            ISSUE_INIT: begin
               wait_cnt <= 16'd0;
               state    <= WAIT_INIT;
            end

            WAIT_INIT: begin
               if (core_ready) begin
                  key_loaded <= 1'b1;
                  state      <= IDLE;
               end else if (wait_expired) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            ISSUE_NEXT: begin
               wait_cnt <= 16'd0;
               state    <= WAIT_NEXT;
            end

            // Acceptance required the result buffer to be empty or draining,
            // so the capture below never overwrites an undelivered result.
            WAIT_NEXT: begin
               if (core_ready && core_result_valid) begin
                  out_block <= core_result;
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end else if (wait_expired) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
